// File: rtl/rs_pkg.sv
// Shared reservation-station types and helpers: entry record, ROB age arithmetic,
// and the codebase-wide field widths the station parameters default to.
package rs_pkg;

    localparam int unsigned PregWidth  = 7;
    localparam int unsigned RobWidth   = 4;
    localparam int unsigned AluOpWidth = 4;

    typedef struct packed {
        logic                  valid;
        logic                  rdy1;
        logic                  rdy2;
        logic [PregWidth-1:0]  prs1;
        logic [PregWidth-1:0]  prs2;
        logic [PregWidth-1:0]  prd;
        logic [RobWidth-1:0]   rob_tag;
        logic [31:0]           imm;
        logic [AluOpWidth-1:0] alu_op;
        logic [31:0]           pc;
    } rs_entry_t;

    // Distance from the ROB head; modular subtraction keeps ordering valid across wrap.
    function automatic logic [RobWidth-1:0] rob_age(input logic [RobWidth-1:0] tag,
                                                    input logic [RobWidth-1:0] head);
        return tag - head;
    endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// Combinational oldest-first selector: a binary reduction tree over request/age pairs.
// On equal ages the lower index wins because the left subtree always holds lower indices.
module rs_oldest_select #(
    parameter int unsigned N    = 8,
    parameter int unsigned AgeW = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]           req_i,
    input  logic [N-1:0][AgeW-1:0] age_i,
    output logic [N-1:0]           gnt_o,
    output logic [IdxW-1:0]        idx_o,
    output logic                   valid_o
);

    localparam int unsigned Leaves = 2 ** IdxW;

    // Heap-indexed tree: node k has children 2k and 2k+1, leaves at Leaves..2*Leaves-1.
    logic [2*Leaves-1:1] node_v;
    logic [AgeW-1:0]     node_age [1:2*Leaves-1];
    logic [IdxW-1:0]     node_idx [1:2*Leaves-1];
    logic                take_left;

    always_comb begin
        node_v    = '0;
        take_left = 1'b0;
        for (int k = 1; k < 2 * int'(Leaves); k++) begin
            node_age[k] = '0;
            node_idx[k] = '0;
        end
        for (int unsigned i = 0; i < N; i++) begin
            node_v[Leaves+i]   = req_i[i];
            node_age[Leaves+i] = age_i[i];
            node_idx[Leaves+i] = IdxW'(i);
        end
        for (int k = int'(Leaves) - 1; k >= 1; k--) begin
            take_left   = node_v[2*k] && (!node_v[2*k+1] || (node_age[2*k] <= node_age[2*k+1]));
            node_v[k]   = node_v[2*k] | node_v[2*k+1];
            node_age[k] = take_left ? node_age[2*k] : node_age[2*k+1];
            node_idx[k] = take_left ? node_idx[2*k] : node_idx[2*k+1];
        end
    end

    assign valid_o = node_v[1];
    assign idx_o   = node_idx[1];

    always_comb begin
        gnt_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            gnt_o[i] = valid_o && (node_idx[1] == IdxW'(i));
        end
    end

endmodule

// File: rtl/rs_wakeup_select.sv
// Reservation station for one execution unit: CDB wakeup, oldest-ready issue by ROB age,
// and partial flush of entries younger than a mispredicting branch.
module rs_wakeup_select
    import rs_pkg::*;
#(
    parameter int unsigned PREG_WIDTH = PregWidth,
    parameter int unsigned ROB_WIDTH  = RobWidth,
    parameter int unsigned RS_SIZE    = 8,
    parameter int unsigned NUM_CDB    = 2,
    localparam int unsigned IdxW = $clog2(RS_SIZE),
    localparam int unsigned CntW = $clog2(RS_SIZE + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_valid,
    input  logic [31:0]                   i_pc,
    input  logic [31:0]                   i_imm,
    input  logic [PREG_WIDTH-1:0]         i_prs1,
    input  logic [PREG_WIDTH-1:0]         i_prs2,
    input  logic [PREG_WIDTH-1:0]         i_prd,
    input  logic [ROB_WIDTH-1:0]          i_rob_tag,
    input  logic [AluOpWidth-1:0]         i_alu_op,
    input  logic                          i_rs1_ready,
    input  logic                          i_rs2_ready,
    output logic                          o_full,
    output logic [CntW-1:0]               o_free_count,
    input  logic [NUM_CDB-1:0]            i_cdb_valid,
    input  logic [NUM_CDB*PREG_WIDTH-1:0] i_cdb_prd,
    input  logic                          i_eu_ready,
    output logic                          o_issue_valid,
    output logic [31:0]                   o_issue_pc,
    output logic [31:0]                   o_issue_imm,
    output logic [PREG_WIDTH-1:0]         o_issue_prs1,
    output logic [PREG_WIDTH-1:0]         o_issue_prs2,
    output logic [PREG_WIDTH-1:0]         o_issue_prd,
    output logic [ROB_WIDTH-1:0]          o_issue_rob_tag,
    output logic [AluOpWidth-1:0]         o_issue_alu_op,
    input  logic [ROB_WIDTH-1:0]          i_rob_head,
    input  logic                          i_flush,
    input  logic [ROB_WIDTH-1:0]          i_flush_rob_tag
);

    rs_entry_t ent_q [RS_SIZE];
    rs_entry_t ent_d [RS_SIZE];

    logic [RS_SIZE-1:0][ROB_WIDTH-1:0] age;
    logic [ROB_WIDTH-1:0]              flush_age;
    logic [RS_SIZE-1:0]                kill;
    logic [RS_SIZE-1:0]                req;
    logic [RS_SIZE-1:0]                gnt;
    logic [IdxW-1:0]                   sel_idx;
    logic                              sel_valid;
    logic [IdxW-1:0]                   alloc_idx;
    logic [CntW-1:0]                   free_cnt;
    logic                              fire;
    logic                              do_alloc;

    function automatic logic cdb_hit(input logic [PREG_WIDTH-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int unsigned p = 0; p < NUM_CDB; p++) begin
            hit = hit | (i_cdb_valid[p] && (i_cdb_prd[p*PREG_WIDTH +: PREG_WIDTH] == tag));
        end
        return hit;
    endfunction

    // Downward scan so the last free slot seen is the lowest index.
    always_comb begin
        free_cnt  = '0;
        alloc_idx = '0;
        for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                free_cnt  = free_cnt + CntW'(1);
                alloc_idx = IdxW'(i);
            end
        end
    end

    assign o_full       = (free_cnt == '0);
    assign o_free_count = free_cnt;

    always_comb begin
        flush_age = rob_age(i_flush_rob_tag, i_rob_head);
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            age[i]  = rob_age(ent_q[i].rob_tag, i_rob_head);
            kill[i] = i_flush && ent_q[i].valid && (age[i] > flush_age);
            req[i]  = ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2 && !kill[i];
        end
    end

    rs_oldest_select #(
        .N    (RS_SIZE),
        .AgeW (ROB_WIDTH)
    ) u_select (
        .req_i   (req),
        .age_i   (age),
        .gnt_o   (gnt),
        .idx_o   (sel_idx),
        .valid_o (sel_valid)
    );

    assign o_issue_valid   = sel_valid;
    assign o_issue_pc      = sel_valid ? ent_q[sel_idx].pc      : '0;
    assign o_issue_imm     = sel_valid ? ent_q[sel_idx].imm     : '0;
    assign o_issue_prs1    = sel_valid ? ent_q[sel_idx].prs1    : '0;
    assign o_issue_prs2    = sel_valid ? ent_q[sel_idx].prs2    : '0;
    assign o_issue_prd     = sel_valid ? ent_q[sel_idx].prd     : '0;
    assign o_issue_rob_tag = sel_valid ? ent_q[sel_idx].rob_tag : '0;
    assign o_issue_alu_op  = sel_valid ? ent_q[sel_idx].alu_op  : '0;

    assign fire     = sel_valid && i_eu_ready;
    assign do_alloc = i_valid && !o_full && !i_flush;

    always_comb begin
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].valid) begin
                if (cdb_hit(ent_q[i].prs1)) ent_d[i].rdy1 = 1'b1;
                if (cdb_hit(ent_q[i].prs2)) ent_d[i].rdy2 = 1'b1;
            end
            if (kill[i] || (fire && gnt[i])) begin
                ent_d[i].valid = 1'b0;
                ent_d[i].rdy1  = 1'b0;
                ent_d[i].rdy2  = 1'b0;
            end
        end
        // Alloc only targets a free slot, so it never collides with the issued one.
        if (do_alloc) begin
            ent_d[alloc_idx].valid   = 1'b1;
            ent_d[alloc_idx].rdy1    = i_rs1_ready || (i_prs1 == '0) || cdb_hit(i_prs1);
            ent_d[alloc_idx].rdy2    = i_rs2_ready || (i_prs2 == '0) || cdb_hit(i_prs2);
            ent_d[alloc_idx].prs1    = i_prs1;
            ent_d[alloc_idx].prs2    = i_prs2;
            ent_d[alloc_idx].prd     = i_prd;
            ent_d[alloc_idx].rob_tag = i_rob_tag;
            ent_d[alloc_idx].imm     = i_imm;
            ent_d[alloc_idx].alu_op  = i_alu_op;
            ent_d[alloc_idx].pc      = i_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                ent_q[i].valid <= 1'b0;
                ent_q[i].rdy1  <= 1'b0;
                ent_q[i].rdy2  <= 1'b0;
            end
        end else begin
            ent_q <= ent_d;
        end
    end

endmodule

// File: tb/tb_rs_wakeup_select.sv
// Directed bench for rs_wakeup_select: an unordered-pool model of the station is
// checked against the DUT every cycle, plus literal expectations at key points.
module tb_rs_wakeup_select;

    localparam int PW = 7;
    localparam int RW = 4;
    localparam int RS = 8;
    localparam int NC = 2;

    logic            clk;
    logic            reset;
    logic            i_valid;
    logic [31:0]     i_pc;
    logic [31:0]     i_imm;
    logic [PW-1:0]   i_prs1;
    logic [PW-1:0]   i_prs2;
    logic [PW-1:0]   i_prd;
    logic [RW-1:0]   i_rob_tag;
    logic [3:0]      i_alu_op;
    logic            i_rs1_ready;
    logic            i_rs2_ready;
    logic            o_full;
    logic [3:0]      o_free_count;
    logic [NC-1:0]   i_cdb_valid;
    logic [NC*PW-1:0] i_cdb_prd;
    logic            i_eu_ready;
    logic            o_issue_valid;
    logic [31:0]     o_issue_pc;
    logic [31:0]     o_issue_imm;
    logic [PW-1:0]   o_issue_prs1;
    logic [PW-1:0]   o_issue_prs2;
    logic [PW-1:0]   o_issue_prd;
    logic [RW-1:0]   o_issue_rob_tag;
    logic [3:0]      o_issue_alu_op;
    logic [RW-1:0]   i_rob_head;
    logic            i_flush;
    logic [RW-1:0]   i_flush_rob_tag;

    int checks = 0;
    int errors = 0;

    rs_wakeup_select dut (
        .clk             (clk),
        .reset           (reset),
        .i_valid         (i_valid),
        .i_pc            (i_pc),
        .i_imm           (i_imm),
        .i_prs1          (i_prs1),
        .i_prs2          (i_prs2),
        .i_prd           (i_prd),
        .i_rob_tag       (i_rob_tag),
        .i_alu_op        (i_alu_op),
        .i_rs1_ready     (i_rs1_ready),
        .i_rs2_ready     (i_rs2_ready),
        .o_full          (o_full),
        .o_free_count    (o_free_count),
        .i_cdb_valid     (i_cdb_valid),
        .i_cdb_prd       (i_cdb_prd),
        .i_eu_ready      (i_eu_ready),
        .o_issue_valid   (o_issue_valid),
        .o_issue_pc      (o_issue_pc),
        .o_issue_imm     (o_issue_imm),
        .o_issue_prs1    (o_issue_prs1),
        .o_issue_prs2    (o_issue_prs2),
        .o_issue_prd     (o_issue_prd),
        .o_issue_rob_tag (o_issue_rob_tag),
        .o_issue_alu_op  (o_issue_alu_op),
        .i_rob_head      (i_rob_head),
        .i_flush         (i_flush),
        .i_flush_rob_tag (i_flush_rob_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an unordered pool of in-flight ops; slot positions are not modelled.
    typedef struct packed {
        logic [RW-1:0] tag;
        logic [PW-1:0] prs1;
        logic [PW-1:0] prs2;
        logic [PW-1:0] prd;
        logic [31:0]   pc;
        logic [31:0]   imm;
        logic [3:0]    op;
        logic          r1;
        logic          r2;
    } m_t;

    m_t mq[$];
    bit known = 0;

    function automatic int age_of(input logic [RW-1:0] t, input logic [RW-1:0] h);
        return (int'(t) - int'(h) + 16) % 16;
    endfunction

    function automatic bit bcast(input logic [PW-1:0] t);
        for (int p = 0; p < NC; p++) begin
            if (i_cdb_valid[p] && (i_cdb_prd[p*PW +: PW] == t)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_cycle();
        int s;
        int best;
        int fa;
        m_t e;
        m_t nq[$];
        s    = -1;
        best = 1000;
        fa   = age_of(i_flush_rob_tag, i_rob_head);
        for (int j = 0; j < mq.size(); j++) begin
            if (mq[j].r1 && mq[j].r2 && !(i_flush && age_of(mq[j].tag, i_rob_head) > fa) &&
                age_of(mq[j].tag, i_rob_head) < best) begin
                best = age_of(mq[j].tag, i_rob_head);
                s    = j;
            end
        end
        e = '0;
        if (s >= 0) e = mq[s];
        check("issue_valid", 32'(o_issue_valid), 32'(s >= 0));
        check("free_count", 32'(o_free_count), 32'(RS - mq.size()));
        check("full", 32'(o_full), 32'(mq.size() == RS));
        check("issue_rob_tag", 32'(o_issue_rob_tag), 32'(e.tag));
        check("issue_pc", o_issue_pc, e.pc);
        check("issue_imm", o_issue_imm, e.imm);
        check("issue_prs1", 32'(o_issue_prs1), 32'(e.prs1));
        check("issue_prs2", 32'(o_issue_prs2), 32'(e.prs2));
        check("issue_prd", 32'(o_issue_prd), 32'(e.prd));
        check("issue_alu_op", 32'(o_issue_alu_op), 32'(e.op));
        for (int j = 0; j < mq.size(); j++) begin
            if (j == s && i_eu_ready) continue;
            if (i_flush && age_of(mq[j].tag, i_rob_head) > fa) continue;
            e = mq[j];
            if (bcast(e.prs1)) e.r1 = 1'b1;
            if (bcast(e.prs2)) e.r2 = 1'b1;
            nq.push_back(e);
        end
        if (i_valid && !i_flush && mq.size() < RS) begin
            e.tag  = i_rob_tag;
            e.prs1 = i_prs1;
            e.prs2 = i_prs2;
            e.prd  = i_prd;
            e.pc   = i_pc;
            e.imm  = i_imm;
            e.op   = i_alu_op;
            e.r1   = i_rs1_ready || (i_prs1 == 0) || bcast(i_prs1);
            e.r2   = i_rs2_ready || (i_prs2 == 0) || bcast(i_prs2);
            nq.push_back(e);
        end
        mq = nq;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            mq.delete();
            known = 1;
        end else if (known) begin
            model_cycle();
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int tag, input int p1, input int p2, input bit r1, input bit r2);
        i_valid     = 1'b1;
        i_rob_tag   = RW'(tag);
        i_prs1      = PW'(p1);
        i_prs2      = PW'(p2);
        i_prd       = PW'(tag + 32);
        i_pc        = 32'h1000 + 32'(tag) * 4;
        i_imm       = 32'h100 + 32'(tag) * 3;
        i_alu_op    = 4'(tag + 1);
        i_rs1_ready = r1;
        i_rs2_ready = r2;
    endtask

    task automatic idle();
        i_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int wrap_exp[3];
        wrap_exp = '{15, 0, 1};
        reset = 1'b1;
        i_valid = 0; i_pc = 0; i_imm = 0; i_prs1 = 0; i_prs2 = 0; i_prd = 0;
        i_rob_tag = 0; i_alu_op = 0; i_rs1_ready = 0; i_rs2_ready = 0;
        i_cdb_valid = 0; i_cdb_prd = 0; i_eu_ready = 0; i_rob_head = 0;
        i_flush = 0; i_flush_rob_tag = 0;
        cyc();
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("reset_free", 32'(o_free_count), 32'd8);
        check("reset_full", 32'(o_full), 32'd0);
        check("reset_valid", 32'(o_issue_valid), 32'd0);
        check("reset_pc", o_issue_pc, 32'd0);
        cyc();

        // Fill, drop the ninth, drain in ROB order.
        for (int k = 0; k < 8; k++) begin
            put(k, 1, 2, 1'b1, 1'b1);
            cyc();
        end
        put(8, 1, 2, 1'b1, 1'b1);
        @(negedge clk);
        check("fill_full", 32'(o_full), 32'd1);
        check("fill_free", 32'(o_free_count), 32'd0);
        cyc();
        idle();
        i_eu_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("drain_tag", 32'(o_issue_rob_tag), 32'(k));
            if (k == 0) check("drop_free", 32'(o_free_count), 32'd0);
            cyc();
        end
        i_eu_ready = 1'b0;
        @(negedge clk);
        check("drain_empty", 32'(o_issue_valid), 32'd0);
        check("drain_free", 32'(o_free_count), 32'd8);
        cyc();

        // CDB wakeup on port 1: issuable the cycle after the broadcast.
        put(0, 5, 3, 1'b0, 1'b1);
        cyc();
        idle();
        @(negedge clk);
        check("wake_wait", 32'(o_issue_valid), 32'd0);
        cyc();
        i_cdb_valid = 2'b10;
        i_cdb_prd   = {7'd5, 7'd0};
        @(negedge clk);
        check("wake_same_cycle", 32'(o_issue_valid), 32'd0);
        cyc();
        i_cdb_valid = 2'b00;
        i_eu_ready  = 1'b1;
        @(negedge clk);
        check("wake_next_valid", 32'(o_issue_valid), 32'd1);
        check("wake_next_tag", 32'(o_issue_rob_tag), 32'd0);
        cyc();
        i_eu_ready = 1'b0;

        // Dispatch-cycle bypass on port 0; prs1 = x0 is ready by definition.
        put(1, 0, 9, 1'b0, 1'b0);
        i_cdb_valid = 2'b01;
        i_cdb_prd   = {7'd0, 7'd9};
        cyc();
        idle();
        i_cdb_valid = 2'b00;
        i_eu_ready  = 1'b1;
        @(negedge clk);
        check("bypass_valid", 32'(o_issue_valid), 32'd1);
        check("bypass_prs2", 32'(o_issue_prs2), 32'd9);
        check("bypass_pc", o_issue_pc, 32'h1004);
        cyc();
        i_eu_ready = 1'b0;

        // Wrap-aware age with head = 14.
        i_rob_head = 4'd14;
        put(1, 1, 2, 1'b1, 1'b1);
        cyc();
        put(0, 1, 2, 1'b1, 1'b1);
        cyc();
        put(15, 1, 2, 1'b1, 1'b1);
        cyc();
        idle();
        i_eu_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("wrap_tag", 32'(o_issue_rob_tag), 32'(wrap_exp[k]));
            cyc();
        end
        i_eu_ready = 1'b0;
        i_rob_head = 4'd0;

        // Partial flush: tags 2..6, flush at 3, concurrent alloc ignored.
        for (int k = 2; k < 7; k++) begin
            put(k, 1, 2, 1'b1, 1'b1);
            cyc();
        end
        idle();
        @(negedge clk);
        check("flush_pre_free", 32'(o_free_count), 32'd3);
        cyc();
        i_flush = 1'b1;
        i_flush_rob_tag = 4'd3;
        put(7, 1, 2, 1'b1, 1'b1);
        @(negedge clk);
        check("flush_sel_tag", 32'(o_issue_rob_tag), 32'd2);
        cyc();
        i_flush = 1'b0;
        idle();
        @(negedge clk);
        check("flush_post_free", 32'(o_free_count), 32'd6);
        cyc();

        // Flush + issue + wakeup + alloc in one cycle.
        put(5, 20, 2, 1'b0, 1'b1);
        cyc();
        put(6, 1, 2, 1'b1, 1'b1);
        cyc();
        i_flush = 1'b1;
        i_flush_rob_tag = 4'd5;
        i_eu_ready = 1'b1;
        i_cdb_valid = 2'b01;
        i_cdb_prd = {7'd0, 7'd20};
        put(7, 1, 2, 1'b1, 1'b1);
        @(negedge clk);
        check("combo_sel_tag", 32'(o_issue_rob_tag), 32'd2);
        cyc();
        i_flush = 1'b0;
        i_cdb_valid = 2'b00;
        idle();
        @(negedge clk);
        check("combo_free", 32'(o_free_count), 32'd6);
        check("combo_tag3", 32'(o_issue_rob_tag), 32'd3);
        cyc();
        @(negedge clk);
        check("combo_tag5", 32'(o_issue_rob_tag), 32'd5);
        cyc();
        i_eu_ready = 1'b0;
        @(negedge clk);
        check("combo_empty", 32'(o_free_count), 32'd8);
        cyc();

        // Back-pressure: selection and payload hold while the unit stalls.
        put(8, 1, 2, 1'b1, 1'b1);
        cyc();
        put(9, 1, 2, 1'b1, 1'b1);
        cyc();
        idle();
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", 32'(o_issue_valid), 32'd1);
            check("stall_pc", o_issue_pc, 32'h1020);
            cyc();
        end
        i_eu_ready = 1'b1;
        @(negedge clk);
        check("stall_tag8", 32'(o_issue_rob_tag), 32'd8);
        cyc();
        @(negedge clk);
        check("stall_tag9", 32'(o_issue_rob_tag), 32'd9);
        cyc();
        i_eu_ready = 1'b0;

        // Reset mid-operation overrides a concurrent alloc and issue.
        put(3, 1, 2, 1'b1, 1'b1);
        cyc();
        put(4, 1, 2, 1'b1, 1'b1);
        cyc();
        reset = 1'b1;
        put(5, 1, 2, 1'b1, 1'b1);
        i_eu_ready = 1'b1;
        cyc();
        reset = 1'b0;
        idle();
        i_eu_ready = 1'b0;
        @(negedge clk);
        check("rst_mid_free", 32'(o_free_count), 32'd8);
        check("rst_mid_valid", 32'(o_issue_valid), 32'd0);
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
